// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency single-port memory between
// the instruction-fetch port and the data port, one transaction at a time.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   output logic              stall_if,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ready,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              stall_mem,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        dbg_state,
   output logic              dbg_last_grant
);

   // Handshake: a port raises req and holds it with stable addr/we/wdata until
   // its ready pulses for exactly one cycle; stall = req & ~ready meanwhile.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic GRANT_IF  = 1'b0;
   localparam logic GRANT_MEM = 1'b1;

   state_t     state;
   state_t     next_state;
   logic [3:0] count;
   logic       grant;
   logic       last_grant;
   logic       pick_mem;

   // Data port wins a conflict unless it was the previous winner.
   assign pick_mem = mem_req & (~if_req | (last_grant == GRANT_IF));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (if_req | mem_req) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (count == 4'd0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ram_en    = (state == ISSUE);
      if_ready  = (state == DONE) && (grant == GRANT_IF);
      mem_ready = (state == DONE) && (grant == GRANT_MEM);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count      <= 4'd0;
         grant      <= GRANT_IF;
         last_grant <= GRANT_IF;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req | mem_req) begin
                  grant      <= pick_mem;
                  last_grant <= pick_mem;
                  if (pick_mem) begin
                     ram_addr  <= mem_addr;
                     ram_we    <= mem_we;
                     ram_wdata <= mem_wdata;
                  end else begin
                     ram_addr  <= if_addr;
                     ram_we    <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               count <= 4'(LAT - 1);
            end
            WAIT: begin
               if (count == 4'd0) begin
                  if (!ram_we) begin
                     if (grant == GRANT_MEM) mem_rdata <= ram_rdata;
                     else                    if_rdata  <= ram_rdata;
                  end
               end else begin
                  count <= count - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_if       = if_req & ~if_ready;
   assign stall_mem      = mem_req & ~mem_ready;
   assign dbg_state      = state;
   assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT 2, 1, 15) each with a
// behavioural fixed-latency RAM; expected read data flows through exp_q.
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   int          cyc;
   int          total;
   int          bad;

   logic        if_req_w     [3];
   logic [31:0] if_addr_w    [3];
   logic        if_ready_w   [3];
   logic [31:0] if_rdata_w   [3];
   logic        stall_if_w   [3];
   logic        mem_req_w    [3];
   logic        mem_we_w     [3];
   logic [31:0] mem_addr_w   [3];
   logic [31:0] mem_wdata_w  [3];
   logic        mem_ready_w  [3];
   logic [31:0] mem_rdata_w  [3];
   logic        stall_mem_w  [3];
   logic        ram_en_w     [3];
   logic        ram_we_w     [3];
   logic [31:0] ram_addr_w   [3];
   logic [31:0] ram_wdata_w  [3];
   logic [31:0] ram_rdata_w  [3];
   logic [1:0]  dbg_state_w  [3];
   logic        dbg_last_w   [3];

   logic [32:0] exp_q[$];
   logic [31:0] model_if  [3];
   logic [31:0] model_mem [3];

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEAD_BEEF;
      return (a * 32'h0100_0193) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      logic [31:0] pd [16];
      logic        pv [16];

      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(L)) dut (
         .clock          (clock),
         .reset          (reset),
         .if_req         (if_req_w[g]),
         .if_addr        (if_addr_w[g]),
         .if_ready       (if_ready_w[g]),
         .if_rdata       (if_rdata_w[g]),
         .stall_if       (stall_if_w[g]),
         .mem_req        (mem_req_w[g]),
         .mem_we         (mem_we_w[g]),
         .mem_addr       (mem_addr_w[g]),
         .mem_wdata      (mem_wdata_w[g]),
         .mem_ready      (mem_ready_w[g]),
         .mem_rdata      (mem_rdata_w[g]),
         .stall_mem      (stall_mem_w[g]),
         .ram_en         (ram_en_w[g]),
         .ram_we         (ram_we_w[g]),
         .ram_addr       (ram_addr_w[g]),
         .ram_wdata      (ram_wdata_w[g]),
         .ram_rdata      (ram_rdata_w[g]),
         .dbg_state      (dbg_state_w[g]),
         .dbg_last_grant (dbg_last_w[g])
      );

      // Read data is valid only in the single cycle the arbiter must capture it.
      always @(posedge clock or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < 16; i++) begin
               pv[i] <= 1'b0;
               pd[i] <= '0;
            end
         end else begin
            pv[0] <= ram_en_w[g] & ~ram_we_w[g];
            pd[0] <= ram_word(ram_addr_w[g]);
            for (int i = 1; i < 16; i++) begin
               pv[i] <= pv[i-1];
               pd[i] <= pd[i-1];
            end
         end
      end
      assign ram_rdata_w[g] = pv[L-1] ? pd[L-1] : 32'hBAD0_BAD0;
   end

   task automatic test_reset();
      logic [134:0] v;
      reset = 1'b1;
      for (int g = 0; g < 3; g++) begin
         if_req_w[g] = 1'b0; if_addr_w[g] = '0;
         mem_req_w[g] = 1'b0; mem_we_w[g] = 1'b0;
         mem_addr_w[g] = '0; mem_wdata_w[g] = '0;
         model_if[g] = '0; model_mem[g] = '0;
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      for (int g = 0; g < 3; g++) begin
         v = {ram_en_w[g], ram_we_w[g], ram_addr_w[g], ram_wdata_w[g], if_ready_w[g],
              mem_ready_w[g], if_rdata_w[g], mem_rdata_w[g], dbg_state_w[g], dbg_last_w[g]};
         total++;
         if (v !== '0) begin
            bad++;
            $display("FAIL reset_values inst=%0d got=%h want=0", g, v);
         end
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic do_mem(input int g, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      logic [31:0] exp_d;
      logic [32:0] e;
      int          n;
      int          en_cnt;
      bit          got;
      bit          stall_ok;
      exp_d = we ? model_mem[g] : ram_word(addr);
      if (!we) model_mem[g] = exp_d;
      exp_q.push_back({1'b1, exp_d});
      @(negedge clock);
      mem_req_w[g] = 1'b1; mem_we_w[g] = we; mem_addr_w[g] = addr; mem_wdata_w[g] = wdata;
      n = 0; en_cnt = 0; got = 1'b0; stall_ok = 1'b1;
      while (!got && n < 60) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (ram_en_w[g]) begin
            en_cnt++;
            total++;
            if (ram_addr_w[g] !== addr || ram_we_w[g] !== we || (we && ram_wdata_w[g] !== wdata)) begin
               bad++;
               $display("FAIL ram_strobe inst=%0d got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                        g, ram_addr_w[g], ram_we_w[g], ram_wdata_w[g], addr, we, wdata);
            end
         end
         if (mem_ready_w[g]) got = 1'b1;
         else if (stall_mem_w[g] !== 1'b1) stall_ok = 1'b0;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL mem_ready_timeout inst=%0d got no ready within 60 cycles", g);
         void'(exp_q.pop_front());
         mem_req_w[g] = 1'b0;
         return;
      end
      e = exp_q.pop_front();
      total++;
      if (mem_rdata_w[g] !== e[31:0] || if_ready_w[g] !== 1'b0) begin
         bad++;
         $display("FAIL mem_rdata inst=%0d got=%h if_ready=%b want=%h if_ready=0",
                  g, mem_rdata_w[g], if_ready_w[g], e[31:0]);
      end
      total++;
      if (n - 1 !== lat_of(g) + 1) begin
         bad++;
         $display("FAIL ready_latency inst=%0d got=%0d want=%0d", g, n - 1, lat_of(g) + 1);
      end
      total++;
      if (en_cnt !== 1) begin
         bad++;
         $display("FAIL ram_en_count inst=%0d got=%0d want=1", g, en_cnt);
      end
      total++;
      if (!stall_ok || stall_mem_w[g] !== 1'b0) begin
         bad++;
         $display("FAIL stall_mem inst=%0d held_ok=%b ready_cycle=%b want 1/0", g, stall_ok, stall_mem_w[g]);
      end
      total++;
      if (if_rdata_w[g] !== model_if[g]) begin
         bad++;
         $display("FAIL if_rdata_kept inst=%0d got=%h want=%h", g, if_rdata_w[g], model_if[g]);
      end
      mem_req_w[g] = 1'b0; mem_we_w[g] = 1'b0;
      @(posedge clock);
      @(negedge clock);
      total++;
      if (mem_ready_w[g] !== 1'b0) begin
         bad++;
         $display("FAIL ready_width inst=%0d got=%b want=0", g, mem_ready_w[g]);
      end
   endtask

   task automatic test_single_load();
      do_mem(0, 1'b0, 32'h10, 32'h0);
   endtask

   task automatic test_store();
      do_mem(0, 1'b1, 32'h20, 32'h1234_5678);
   endtask

   task automatic test_reset_mid_wait();
      logic [134:0] v;
      logic [32:0]  e;
      int           n;
      bit           got;
      @(negedge clock);
      mem_req_w[0] = 1'b1; mem_we_w[0] = 1'b0; mem_addr_w[0] = 32'h30; mem_wdata_w[0] = '0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      v = {ram_en_w[0], ram_we_w[0], ram_addr_w[0], ram_wdata_w[0], if_ready_w[0],
           mem_ready_w[0], if_rdata_w[0], mem_rdata_w[0], dbg_state_w[0], dbg_last_w[0]};
      total++;
      if (v !== '0) begin
         bad++;
         $display("FAIL mid_reset_values got=%h want=0", v);
      end
      for (int g = 0; g < 3; g++) begin
         model_if[g] = '0;
         model_mem[g] = '0;
      end
      #2 reset = 1'b0;
      model_mem[0] = ram_word(32'h30);
      exp_q.push_back({1'b1, model_mem[0]});
      @(posedge clock);
      @(negedge clock);
      total++;
      if (ram_en_w[0] !== 1'b1 || ram_addr_w[0] !== 32'h30) begin
         bad++;
         $display("FAIL restart_issue got en=%b addr=%h want en=1 addr=00000030", ram_en_w[0], ram_addr_w[0]);
      end
      n = 1; got = 1'b0;
      while (!got && n < 60) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (mem_ready_w[0]) got = 1'b1;
      end
      e = exp_q.pop_front();
      total++;
      if (!got || n - 1 !== lat_of(0) + 1 || mem_rdata_w[0] !== e[31:0]) begin
         bad++;
         $display("FAIL restart_load got ready=%b edges=%0d data=%h want ready=1 edges=%0d data=%h",
                  got, n - 1, mem_rdata_w[0], lat_of(0) + 1, e[31:0]);
      end
      mem_req_w[0] = 1'b0;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_conflict();
      logic [32:0] e;
      int          nready;
      int          n;
      bit          prev;
      bit          stall_ok;
      @(negedge clock);
      reset = 1'b1;
      for (int g = 0; g < 3; g++) begin
         model_if[g] = '0;
         model_mem[g] = '0;
      end
      if_req_w[0] = 1'b1; if_addr_w[0] = 32'h40;
      mem_req_w[0] = 1'b1; mem_we_w[0] = 1'b0; mem_addr_w[0] = 32'h10;
      exp_q.push_back({1'b1, ram_word(32'h10)});
      exp_q.push_back({1'b0, ram_word(32'h40)});
      exp_q.push_back({1'b1, ram_word(32'h10)});
      exp_q.push_back({1'b0, ram_word(32'h40)});
      @(negedge clock);
      reset = 1'b0;
      nready = 0; n = 0; prev = 1'b0; stall_ok = 1'b1;
      while (nready < 4 && n < 100) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (nready == 0 && stall_if_w[0] !== 1'b1) stall_ok = 1'b0;
         if (if_ready_w[0] || mem_ready_w[0]) begin
            e = exp_q.pop_front();
            total++;
            if (if_ready_w[0] === mem_ready_w[0] || mem_ready_w[0] !== e[32] || prev ||
                (e[32] ? mem_rdata_w[0] : if_rdata_w[0]) !== e[31:0]) begin
               bad++;
               $display("FAIL grant_order n=%0d got if=%b mem=%b data=%h prev=%b want mem=%b data=%h",
                        nready, if_ready_w[0], mem_ready_w[0],
                        e[32] ? mem_rdata_w[0] : if_rdata_w[0], prev, e[32], e[31:0]);
            end
            nready++;
            prev = 1'b1;
            if (nready == 4) begin
               if_req_w[0] = 1'b0;
               mem_req_w[0] = 1'b0;
            end
         end else begin
            prev = 1'b0;
         end
      end
      total++;
      if (nready !== 4) begin
         bad++;
         $display("FAIL conflict_count got=%0d want=4", nready);
      end
      total++;
      if (!stall_ok) begin
         bad++;
         $display("FAIL stall_if_first got=0 want=1 throughout first data transaction");
      end
      while (exp_q.size() > 0) void'(exp_q.pop_front());
      model_if[0] = ram_word(32'h40);
      model_mem[0] = ram_word(32'h10);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [32:0] e;
      int          en_cyc [3];
      int          ne;
      int          k;
      int          n;
      @(negedge clock);
      if_req_w[0] = 1'b1; if_addr_w[0] = 32'h0;
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, ram_word(32'(4 * i))});
      ne = 0; k = 0; n = 0;
      while (k < 3 && n < 80) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (ram_en_w[0] && ne < 3) begin
            en_cyc[ne] = cyc;
            total++;
            if (ram_we_w[0] !== 1'b0 || ram_addr_w[0] !== 32'(4 * ne)) begin
               bad++;
               $display("FAIL fetch_issue n=%0d got we=%b addr=%h want we=0 addr=%h",
                        ne, ram_we_w[0], ram_addr_w[0], 32'(4 * ne));
            end
            ne++;
         end
         if (if_ready_w[0]) begin
            e = exp_q.pop_front();
            total++;
            if (if_rdata_w[0] !== e[31:0]) begin
               bad++;
               $display("FAIL fetch_data n=%0d got=%h want=%h", k, if_rdata_w[0], e[31:0]);
            end
            k++;
            if (k < 3) if_addr_w[0] = 32'(4 * k);
            else if_req_w[0] = 1'b0;
         end
      end
      total++;
      if (k !== 3 || ne !== 3) begin
         bad++;
         $display("FAIL fetch_count got ready=%0d issue=%0d want 3/3", k, ne);
      end else begin
         for (int i = 1; i < 3; i++) begin
            total++;
            if (en_cyc[i] - en_cyc[i-1] !== lat_of(0) + 3) begin
               bad++;
               $display("FAIL fetch_spacing i=%0d got=%0d want=%0d", i, en_cyc[i] - en_cyc[i-1], lat_of(0) + 3);
            end
         end
      end
      while (exp_q.size() > 0) void'(exp_q.pop_front());
      model_if[0] = ram_word(32'h8);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_latency_sweep();
      do_mem(1, 1'b0, 32'h10, 32'h0);
      do_mem(2, 1'b0, 32'h10, 32'h0);
      do_mem(2, 1'b0, 32'h24, 32'h0);
   endtask

   initial begin
      cyc = 0; total = 0; bad = 0;
      test_reset();
      test_single_load();
      test_store();
      test_reset_mid_wait();
      test_conflict();
      test_back_to_back();
      test_latency_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
